// File: rtl/oam_dma_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// oam_dma_ctrl_pkg
// Shared constants and types for the OAM DMA controller.
//   dma_state_t            : controller state encoding (IDLE, START, READ, WRITE)
//   DMA_REG_ADDR_DEFAULT   : CPU-visible trigger/page register address
//   OAM_BASE_DEFAULT       : destination base address of the OAM copy
//   DMA_LEN_DEFAULT        : bytes moved per transfer
// ----------------------------------------------------------------------------
package oam_dma_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StRead  = 2'd2,
        StWrite = 2'd3
    } dma_state_t;

    localparam logic [15:0] DMA_REG_ADDR_DEFAULT = 16'hFF46;
    localparam logic [15:0] OAM_BASE_DEFAULT     = 16'hFE00;
    localparam int unsigned DMA_LEN_DEFAULT      = 160;

endpackage

// File: rtl/oam_dma_ctrl.sv
// ----------------------------------------------------------------------------
// oam_dma_ctrl
// OAM DMA engine sharing a single memory port with the CPU. A CPU write to the
// DMA register latches a source page and copies DMA_LEN bytes from
// {page, idx} to OAM_BASE + idx, two cycles per byte, after a one-cycle START.
// While a transfer runs the CPU is stalled for every access except the DMA
// register itself, which is handled locally and never reaches memory.
//
// Ports
//   clk_i        system clock, rising edge
//   rst_i        asynchronous active-high reset
//   cpu_addr_i   CPU address
//   cpu_wdata_i  CPU write data
//   cpu_re_i     CPU read strobe
//   cpu_we_i     CPU write strobe
//   cpu_rdata_o  data returned to the CPU
//   cpu_stall_o  CPU access not granted this cycle
//   mem_addr_o   shared memory address
//   mem_wdata_o  shared memory write data
//   mem_re_o     shared memory read strobe
//   mem_we_o     shared memory write strobe
//   mem_rdata_i  memory read data, same cycle as mem_re_o
//   dma_busy_o   high whenever a transfer is in progress
// ----------------------------------------------------------------------------
module oam_dma_ctrl
    import oam_dma_ctrl_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR = DMA_REG_ADDR_DEFAULT,
    parameter logic [15:0] OAM_BASE     = OAM_BASE_DEFAULT,
    parameter int unsigned DMA_LEN      = DMA_LEN_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] cpu_addr_i,
    input  logic [7:0]  cpu_wdata_i,
    input  logic        cpu_re_i,
    input  logic        cpu_we_i,
    output logic [7:0]  cpu_rdata_o,
    output logic        cpu_stall_o,
    output logic [15:0] mem_addr_o,
    output logic [7:0]  mem_wdata_o,
    output logic        mem_re_o,
    output logic        mem_we_o,
    input  logic [7:0]  mem_rdata_i,
    output logic        dma_busy_o
);

    localparam logic [7:0] LastIdx = 8'(DMA_LEN - 1);

    dma_state_t state_q, state_d;
    logic [7:0] page_q, page_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] data_q, data_d;

    logic reg_hit;
    logic reg_wr;
    logic cpu_req;
    logic busy;

    assign reg_hit = (cpu_addr_i == DMA_REG_ADDR);
    assign reg_wr  = reg_hit & cpu_we_i;
    assign cpu_req = cpu_re_i | cpu_we_i;
    assign busy    = (state_q != StIdle);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        idx_d   = idx_q;
        data_d  = data_q;

        case (state_q)
            StIdle: begin
                state_d = StIdle;
            end
            StStart: begin
                state_d = StRead;
            end
            StRead: begin
                data_d  = mem_rdata_i;
                state_d = StWrite;
            end
            StWrite: begin
                if (idx_q == LastIdx) begin
                    state_d = StIdle;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = StRead;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // A register write wins over everything, restarting any running copy.
        if (reg_wr) begin
            page_d  = cpu_wdata_i;
            idx_d   = 8'd0;
            state_d = StStart;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            page_q  <= 8'h00;
            idx_q   <= 8'h00;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

    // ------------------------------------------------------------------------
    // Memory port mux and CPU handshake
    // ------------------------------------------------------------------------
    always_comb begin
        mem_addr_o  = cpu_addr_i;
        mem_wdata_o = cpu_wdata_i;
        mem_re_o    = 1'b0;
        mem_we_o    = 1'b0;
        cpu_stall_o = 1'b0;
        cpu_rdata_o = mem_rdata_i;

        case (state_q)
            StIdle: begin
                // Pass-through; the DMA register is serviced locally.
                mem_re_o = cpu_re_i & ~reg_hit;
                mem_we_o = cpu_we_i & ~reg_hit;
            end
            StStart: begin
                mem_addr_o  = 16'h0000;
                mem_wdata_o = 8'h00;
                cpu_stall_o = cpu_req & ~reg_hit;
            end
            StRead: begin
                mem_addr_o  = {page_q, idx_q};
                mem_wdata_o = 8'h00;
                mem_re_o    = 1'b1;
                cpu_stall_o = cpu_req & ~reg_hit;
            end
            StWrite: begin
                // idx never exceeds DMA_LEN-1, so the sum stays inside OAM.
                mem_addr_o  = OAM_BASE + {8'h00, idx_q};
                mem_wdata_o = data_q;
                mem_we_o    = 1'b1;
                cpu_stall_o = cpu_req & ~reg_hit;
            end
            default: begin
                mem_addr_o = cpu_addr_i;
            end
        endcase

        if (reg_hit && cpu_re_i) begin
            cpu_rdata_o = page_q;
        end
    end

    assign dma_busy_o = busy;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
module tb_oam_dma_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_re;
    logic        cpu_we;
    logic [7:0]  cpu_rdata;
    logic        cpu_stall;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_re;
    logic        mem_we;
    logic [7:0]  mem_rdata;
    logic        dma_busy;

    int n_cmp  = 0;
    int n_fail = 0;
    int stray  = 0;

    logic [7:0] mem [0:65535];

    always #5 clk = ~clk;

    oam_dma_ctrl dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cpu_addr_i  (cpu_addr),
        .cpu_wdata_i (cpu_wdata),
        .cpu_re_i    (cpu_re),
        .cpu_we_i    (cpu_we),
        .cpu_rdata_o (cpu_rdata),
        .cpu_stall_o (cpu_stall),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_re_o    (mem_re),
        .mem_we_o    (mem_we),
        .mem_rdata_i (mem_rdata),
        .dma_busy_o  (dma_busy)
    );

    // Memory model: combinational read, write on rising edge.
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] = mem_wdata;
    end

    // Any write outside OAM while a transfer runs is a side effect.
    always @(posedge clk) begin
        if (dma_busy && mem_we && (mem_addr < 16'hFE00 || mem_addr > 16'hFE9F)) stray++;
    end

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        re;
        logic        we;
        logic        stall;
        logic        mre;
        logic        mwe;
        logic [15:0] maddr;
        logic [7:0]  mwdata;
        logic [7:0]  rdata;
        logic        chk_rd;
    } vec_t;

    vec_t tv [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_idle();
        cpu_addr  = 16'h0000;
        cpu_wdata = 8'h00;
        cpu_re    = 1'b0;
        cpu_we    = 1'b0;
    endtask

    task automatic trigger(input logic [7:0] page);
        cpu_addr  = 16'hFF46;
        cpu_wdata = page;
        cpu_we    = 1'b1;
        cpu_re    = 1'b0;
        tick();
        cpu_idle();
    endtask

    // Counts busy cycles from now on; returns at the falling edge of the first idle cycle.
    task automatic count_busy(output int cnt);
        cnt = 0;
        for (int j = 0; j < 400; j++) begin
            @(negedge clk);
            if (!dma_busy) break;
            if (j == 0) chk("start_port_idle", {mem_re, mem_we}, 2'b00);
            cnt++;
            tick();
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : main
        int cnt;
        int errs;
        int stalled;
        int sidefx;

        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        mem[16'h8000] = 8'h99;
        mem[16'h0000] = 8'h3C;

        //              addr     wd     re    we    stl   mre   mwe   maddr    mwd    rd     chk
        tv[0] = '{16'h1234, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, 8'h00, 8'h00, 1'b0};
        tv[1] = '{16'hC000, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'hC000, 8'h77, 8'h00, 1'b0};
        tv[2] = '{16'hC000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'hC000, 8'h00, 8'h77, 1'b1};
        tv[3] = '{16'hFF46, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'hFF46, 8'h00, 8'h00, 1'b1};
        tv[4] = '{16'h8000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h8000, 8'h00, 8'h99, 1'b1};
        tv[5] = '{16'hFE10, 8'hAB, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'hFE10, 8'hAB, 8'h00, 1'b0};

        // Reset behaviour, including pass-through of a CPU read during reset.
        rst = 1'b1;
        cpu_idle();
        #1;
        chk("rst_busy", dma_busy, 1'b0);
        chk("rst_stall", cpu_stall, 1'b0);
        chk("rst_mem_strobes", {mem_re, mem_we}, 2'b00);
        cpu_addr = 16'h1234;
        cpu_re   = 1'b1;
        #1;
        chk("rst_passthru_re", mem_re, 1'b1);
        chk("rst_passthru_addr", mem_addr, 16'h1234);
        cpu_idle();
        tick();
        tick();
        rst = 1'b0;

        // Idle pass-through vectors.
        for (int i = 0; i < 6; i++) begin
            cpu_addr  = tv[i].addr;
            cpu_wdata = tv[i].wdata;
            cpu_re    = tv[i].re;
            cpu_we    = tv[i].we;
            @(negedge clk);
            chk($sformatf("vec%0d_stall", i), cpu_stall, tv[i].stall);
            chk($sformatf("vec%0d_mem_re", i), mem_re, tv[i].mre);
            chk($sformatf("vec%0d_mem_we", i), mem_we, tv[i].mwe);
            chk($sformatf("vec%0d_mem_addr", i), mem_addr, tv[i].maddr);
            chk($sformatf("vec%0d_mem_wdata", i), mem_wdata, tv[i].mwdata);
            chk($sformatf("vec%0d_busy", i), dma_busy, 1'b0);
            if (tv[i].chk_rd) chk($sformatf("vec%0d_rdata", i), cpu_rdata, tv[i].rdata);
            tick();
        end
        cpu_idle();
        chk("idle_write_c000", mem[16'hC000], 8'h77);
        chk("idle_write_fe10", mem[16'hFE10], 8'hAB);

        // Full C1 transfer with timing spot checks and a mid-transfer register read.
        for (int k = 0; k < 160; k++) begin
            mem[16'hC100 + k] = 8'(k) ^ 8'h5A;
            mem[16'hFE00 + k] = 8'hEE;
        end
        mem[16'hFEA0] = 8'hEE;
        trigger(8'hC1);
        cnt = 0;
        for (int j = 0; j < 400; j++) begin
            if (j == 100) begin
                cpu_addr = 16'hFF46;
                cpu_re   = 1'b1;
            end
            @(negedge clk);
            if (!dma_busy) break;
            cnt++;
            if (j == 0) chk("c1_start_strobes", {mem_re, mem_we}, 2'b00);
            if (j == 1) begin
                chk("c1_first_read_re", mem_re, 1'b1);
                chk("c1_first_read_addr", mem_addr, 16'hC100);
            end
            if (j == 2) begin
                chk("c1_first_write_we", mem_we, 1'b1);
                chk("c1_first_write_addr", mem_addr, 16'hFE00);
                chk("c1_first_write_data", mem_wdata, 8'h5A);
            end
            if (j == 100) begin
                chk("midread_rdata", cpu_rdata, 8'hC1);
                chk("midread_stall", cpu_stall, 1'b0);
                chk("midread_mem_re", mem_re, 1'b0);
            end
            if (j == 320) begin
                chk("c1_last_write_addr", mem_addr, 16'hFE9F);
                chk("c1_last_write_data", mem_wdata, 8'hC5);
            end
            tick();
            cpu_idle();
        end
        chk("c1_busy_cycles", cnt, 321);
        tick();
        errs = 0;
        for (int k = 0; k < 160; k++) if (mem[16'hFE00 + k] !== (8'(k) ^ 8'h5A)) errs++;
        chk("c1_oam_copy_errors", errs, 0);
        chk("c1_fea0_untouched", mem[16'hFEA0], 8'hEE);

        // Held CPU read of 0000 is stalled for the whole transfer, then granted.
        trigger(8'hC1);
        cpu_addr = 16'h0000;
        cpu_re   = 1'b1;
        stalled  = 0;
        sidefx   = 0;
        for (int j = 0; j < 400; j++) begin
            @(negedge clk);
            if (!dma_busy) break;
            if (cpu_stall) stalled++;
            if (mem_re && mem_addr == 16'h0000) sidefx++;
            tick();
        end
        chk("stall_cycles", stalled, 321);
        chk("stall_side_effects", sidefx, 0);
        chk("grant_stall", cpu_stall, 1'b0);
        chk("grant_mem_re", mem_re, 1'b1);
        chk("grant_mem_addr", mem_addr, 16'h0000);
        chk("grant_rdata", cpu_rdata, 8'h3C);
        tick();
        cpu_idle();

        // Restart with page D0 during byte 50 of a C1 transfer.
        for (int k = 0; k < 160; k++) begin
            mem[16'hD000 + k] = 8'(k * 3 + 1);
            mem[16'hFE00 + k] = 8'hEE;
        end
        trigger(8'hC1);
        repeat (100) tick();
        trigger(8'hD0);
        count_busy(cnt);
        chk("restart_busy_cycles", cnt, 321);
        tick();
        errs = 0;
        for (int k = 0; k < 160; k++) if (mem[16'hFE00 + k] !== 8'(k * 3 + 1)) errs++;
        chk("restart_oam_copy_errors", errs, 0);

        // Reset asserted while byte 80 is being read.
        for (int k = 0; k < 160; k++) mem[16'hFE00 + k] = 8'h11;
        trigger(8'hC1);
        repeat (161) tick();
        chk("pre_reset_read_addr", mem_addr, 16'hC150);
        rst = 1'b1;
        #1;
        chk("reset_abort_busy", dma_busy, 1'b0);
        chk("reset_abort_we", mem_we, 1'b0);
        chk("reset_abort_stall", cpu_stall, 1'b0);
        tick();
        chk("reset_hold_we", mem_we, 1'b0);
        rst = 1'b0;
        cpu_addr = 16'hFF46;
        cpu_re   = 1'b1;
        @(negedge clk);
        chk("reset_page_read", cpu_rdata, 8'h00);
        chk("reset_page_mem_re", mem_re, 1'b0);
        chk("reset_busy_after", dma_busy, 1'b0);
        tick();
        cpu_idle();
        repeat (3) tick();
        chk("reset_stays_idle", {dma_busy, mem_we}, 2'b00);
        errs = 0;
        for (int k = 0; k < 80; k++) if (mem[16'hFE00 + k] !== (8'(k) ^ 8'h5A)) errs++;
        for (int k = 80; k < 160; k++) if (mem[16'hFE00 + k] !== 8'h11) errs++;
        chk("reset_oam_contents_errors", errs, 0);

        chk("stray_writes_while_busy", stray, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
